// File: rtl/burst_mem_pkg.sv
// Shared definitions for the burst memory responder.
//   state_t         : responder FSM states
//   BYTE_W          : bits per byte lane
//   bytes_per_word  : bytes in one data word of a given width
//   log2_ceil       : ceiling log2, used for shift amounts and counter widths
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/burst_addr_counter.sv
// Word address / word count tracker for one burst.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   load         : start of burst; word 0 is serviced directly from base, so
//                  the counter is primed to point at word 1
//   inc          : advance to the next word
//   base         : burst start word address
//   addr         : word address of the next word to service
//   cnt          : number of words already serviced in this burst
//   last         : the next word to service is the final one of the burst
module burst_addr_counter #(
  parameter int AW           = 10,
  parameter int CNT_W        = 3,
  parameter int BURST_LENGTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [AW-1:0]    base,
  output logic [AW-1:0]    addr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LENGTH - 1);

  // Address wraps naturally at 2^AW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base + AW'(1);
      cnt  <= CNT_W'(1);
    end else if (inc) begin
      addr <= addr + AW'(1);
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the burst memory protocol. Accepts read/write
// bursts and serves them from a single-port synchronous backing store.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   io_in_rd/wr         : read burst request / write request and word strobe
//   io_in_addr          : burst start byte address, sampled at acceptance
//   io_in_din           : write data, one word per accepted write cycle
//   io_in_dout          : read data (mem_dout pass-through), qualified by io_in_valid
//   io_in_wait_n        : request or write word accepted this cycle
//   io_in_valid         : io_in_dout holds a read word
//   io_in_burstDone     : final word of the current burst
//   mem_rd/mem_wr       : backing store strobes, only high when accepted
//   mem_addr/mem_din    : backing store word address / write data, held when idle
//   mem_dout            : backing store read data, one cycle after mem_rd
//   mem_ready           : backing store can accept a strobe this cycle
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 4,
  parameter int MEM_AW       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_rd,
  input  logic                  io_in_wr,
  input  logic [ADDR_WIDTH-1:0] io_in_addr,
  input  logic [DATA_WIDTH-1:0] io_in_din,
  output logic [DATA_WIDTH-1:0] io_in_dout,
  output logic                  io_in_wait_n,
  output logic                  io_in_valid,
  output logic                  io_in_burstDone,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_ready
);

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int SHIFT          = log2_ceil(BYTES_PER_WORD);
  localparam int CNT_W          = log2_ceil(BURST_LENGTH + 1);

  localparam logic [CNT_W-1:0] BL_CNT   = CNT_W'(BURST_LENGTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LENGTH - 1);

  state_t                state, state_nxt;
  logic [MEM_AW-1:0]     base_addr;
  logic [MEM_AW-1:0]     ctr_addr;
  logic [CNT_W-1:0]      ctr_cnt;
  logic                  ctr_last;
  logic                  ctr_load;
  logic                  ctr_inc;
  logic [CNT_W-1:0]      ret_cnt;
  logic                  ret_clr;
  logic                  vld_p1;
  logic [MEM_AW-1:0]     addr_hold;
  logic [DATA_WIDTH-1:0] din_hold;
  logic                  mem_ok;
  logic                  wait_c;
  logic                  rd_c;
  logic                  wr_c;
  logic                  done_c;
  logic [MEM_AW-1:0]     addr_c;
  logic [DATA_WIDTH-1:0] din_c;

  // Byte address to word address; upper bits beyond MEM_AW are dropped.
  assign base_addr = MEM_AW'(io_in_addr >> SHIFT);

  // Folding reset into the ready term forces every combinational strobe and
  // wait_n low the instant reset asserts, without waiting for a clock edge.
  assign mem_ok = mem_ready & reset;

  burst_addr_counter #(
    .AW           (MEM_AW),
    .CNT_W        (CNT_W),
    .BURST_LENGTH (BURST_LENGTH)
  ) u_addr_counter (
    .clock (clock),
    .reset (reset),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .base  (base_addr),
    .addr  (ctr_addr),
    .cnt   (ctr_cnt),
    .last  (ctr_last)
  );

  // Stage p0: request decode, strobe generation and next state.
  always_comb begin
    state_nxt = state;
    wait_c    = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    done_c    = 1'b0;
    addr_c    = addr_hold;
    din_c     = din_hold;
    ctr_load  = 1'b0;
    ctr_inc   = 1'b0;
    ret_clr   = 1'b0;
    case (state)
      IDLE: begin
        wait_c = mem_ok;
        if (io_in_wr && mem_ok) begin
          wr_c   = 1'b1;
          addr_c = base_addr;
          din_c  = io_in_din;
          if (BURST_LENGTH == 1) begin
            done_c = 1'b1;
          end else begin
            state_nxt = WRITE;
            ctr_load  = 1'b1;
          end
        end else if (io_in_rd && mem_ok) begin
          // Single-word reads still pass through READ to collect the return.
          rd_c      = 1'b1;
          addr_c    = base_addr;
          state_nxt = READ;
          ctr_load  = 1'b1;
          ret_clr   = 1'b1;
        end
      end
      WRITE: begin
        wait_c = mem_ok;
        if (io_in_wr && mem_ok) begin
          wr_c    = 1'b1;
          addr_c  = ctr_addr;
          din_c   = io_in_din;
          ctr_inc = 1'b1;
          if (ctr_last) begin
            done_c    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      READ: begin
        // Issue is throttled by mem_ready; returns of already-issued words
        // continue regardless, so valids may have gaps.
        if ((ctr_cnt != BL_CNT) && mem_ok) begin
          rd_c    = 1'b1;
          addr_c  = ctr_addr;
          ctr_inc = 1'b1;
        end
        if (vld_p1 && (ret_cnt == LAST_CNT)) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: state, read-return valid and held address/data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      ret_cnt   <= '0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      state     <= state_nxt;
      vld_p1    <= rd_c;
      addr_hold <= addr_c;
      din_hold  <= din_c;
      if (ret_clr) begin
        ret_cnt <= '0;
      end else if (vld_p1) begin
        ret_cnt <= ret_cnt + CNT_W'(1);
      end
    end
  end

  assign io_in_wait_n    = wait_c;
  assign io_in_valid     = vld_p1;
  assign io_in_burstDone = done_c;
  assign io_in_dout      = reset ? mem_dout : '0;
  assign mem_rd          = rd_c;
  assign mem_wr          = wr_c;
  assign mem_addr        = addr_c;
  assign mem_din         = din_c;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

  logic        clock;
  logic        reset;
  logic        io_in_rd;
  logic        io_in_wr;
  logic [24:0] io_in_addr;
  logic [15:0] io_in_din;
  logic [15:0] io_in_dout;
  logic        io_in_wait_n;
  logic        io_in_valid;
  logic        io_in_burstDone;
  logic        mem_rd;
  logic        mem_wr;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t exp_wr[$];
  exp_t exp_ra[$];
  exp_t exp_val[$];
  exp_t mon_e;

  logic [15:0] mem [1024];

  burst_mem_responder #(
    .ADDR_WIDTH   (25),
    .DATA_WIDTH   (16),
    .BURST_LENGTH (4),
    .MEM_AW       (10)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_rd        (io_in_rd),
    .io_in_wr        (io_in_wr),
    .io_in_addr      (io_in_addr),
    .io_in_din       (io_in_din),
    .io_in_dout      (io_in_dout),
    .io_in_wait_n    (io_in_wait_n),
    .io_in_valid     (io_in_valid),
    .io_in_burstDone (io_in_burstDone),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .mem_ready       (mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Backing store model: synchronous write, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_wr && mem_ready) mem[mem_addr] <= mem_din;
    if (mem_rd && mem_ready) mem_dout <= mem[mem_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or valid.
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (mem_rd && mem_wr) begin
        errors++;
        $display("FAIL strobe_excl: mem_rd=%b mem_wr=%b, required not both 1", mem_rd, mem_wr);
      end
      checks++;
      if (io_in_burstDone && !mem_wr && !io_in_valid) begin
        errors++;
        $display("FAIL stray_done: burstDone=1 at cyc %0d with no write or valid", cyc);
      end
      if (mem_wr) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_word: unexpected mem_wr addr=%h data=%h at cyc %0d", mem_addr, mem_din, cyc);
        end else begin
          mon_e = exp_wr.pop_front();
          if (mem_addr !== mon_e.addr || mem_din !== mon_e.data || io_in_burstDone !== mon_e.done ||
              cyc != mon_e.cyc || io_in_wait_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_word: got addr=%h data=%h done=%b wait_n=%b cyc=%0d, required addr=%h data=%h done=%b wait_n=1 cyc=%0d",
                     mem_addr, mem_din, io_in_burstDone, io_in_wait_n, cyc,
                     mon_e.addr, mon_e.data, mon_e.done, mon_e.cyc);
          end
        end
      end
      if (mem_rd) begin
        checks++;
        if (exp_ra.size() == 0) begin
          errors++;
          $display("FAIL rd_issue: unexpected mem_rd addr=%h at cyc %0d", mem_addr, cyc);
        end else begin
          mon_e = exp_ra.pop_front();
          if (mem_addr !== mon_e.addr || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL rd_issue: got addr=%h cyc=%0d, required addr=%h cyc=%0d",
                     mem_addr, cyc, mon_e.addr, mon_e.cyc);
          end
        end
      end
      if (io_in_valid) begin
        checks++;
        if (exp_val.size() == 0) begin
          errors++;
          $display("FAIL rd_valid: unexpected valid dout=%h at cyc %0d", io_in_dout, cyc);
        end else begin
          mon_e = exp_val.pop_front();
          if (io_in_dout !== mon_e.data || io_in_burstDone !== mon_e.done || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL rd_valid: got dout=%h done=%b cyc=%0d, required dout=%h done=%b cyc=%0d",
                     io_in_dout, io_in_burstDone, cyc, mon_e.data, mon_e.done, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push(ref exp_t q[$], input logic [9:0] a, input logic [15:0] d,
                      input logic dn, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.done = dn;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_wr.size() == 0 && exp_ra.size() == 0 && exp_val.size() == 0) break;
      @(negedge clock);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_ra.size() != 0 || exp_val.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending wr=%0d rd=%0d val=%0d, required 0",
               exp_wr.size(), exp_ra.size(), exp_val.size());
      exp_wr.delete();
      exp_ra.delete();
      exp_val.delete();
    end
  endtask

  // Four-word write; gap_after >= 0 drops wr for one cycle (with rd high)
  // after that word index.
  task automatic do_write(input logic [24:0] baddr, input logic [9:0] a [4],
                          input logic [15:0] d0, input logic both_rd, input int gap_after);
    step();
    io_in_addr = baddr;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (gap_after >= 0 && i == gap_after + 1) begin
        io_in_wr  = 1'b0;
        io_in_rd  = 1'b1;
        io_in_din = 16'hDEAD;
        step();
      end
      io_in_wr  = 1'b1;
      io_in_rd  = (i == 0) ? both_rd : 1'b0;
      io_in_din = d0 + 16'(i);
      push(exp_wr, a[i], d0 + 16'(i), (i == 3), cyc);
    end
    step();
    io_in_wr = 1'b0;
    io_in_rd = 1'b0;
    drain();
  endtask

  // Four-word read; stall cycles of mem_ready low right after the first issue.
  task automatic do_read(input logic [24:0] baddr, input logic [9:0] a [4],
                         input logic [15:0] d0, input int stall);
    int acc;
    step();
    io_in_rd   = 1'b1;
    io_in_addr = baddr;
    acc        = cyc;
    push(exp_ra, a[0], 16'h0, 1'b0, acc);
    for (int i = 1; i < 4; i++) push(exp_ra, a[i], 16'h0, 1'b0, acc + i + stall);
    push(exp_val, 10'h0, d0, 1'b0, acc + 1);
    for (int i = 1; i < 4; i++) push(exp_val, 10'h0, d0 + 16'(i), (i == 3), acc + 1 + i + stall);
    @(negedge clock);
    chk("rd_accept_wait_n", 32'(io_in_wait_n), 32'd1);
    step();
    io_in_rd  = 1'b0;
    mem_ready = (stall == 0);
    @(negedge clock);
    chk("rd_busy_wait_n", 32'(io_in_wait_n), 32'd0);
    for (int k = 1; k < stall; k++) step();
    if (stall > 0) begin
      step();
      mem_ready = 1'b1;
    end
    drain();
  endtask

  logic [9:0] av [4];
  int         acc6;

  initial begin
    reset      = 1'b0;
    io_in_rd   = 1'b1;
    io_in_wr   = 1'b1;
    io_in_addr = 25'h100;
    io_in_din  = 16'h5555;
    mem_ready  = 1'b1;

    // Reset state with requests held high.
    @(negedge clock);
    chk("rst_wait_n", 32'(io_in_wait_n), 32'd0);
    chk("rst_valid", 32'(io_in_valid), 32'd0);
    chk("rst_done", 32'(io_in_burstDone), 32'd0);
    chk("rst_dout", 32'(io_in_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    step();
    io_in_rd = 1'b0;
    io_in_wr = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk("idle_wait_n", 32'(io_in_wait_n), 32'd1);

    // 1: write burst at byte 0x100 -> words 0x80..0x83.
    av = '{10'h080, 10'h081, 10'h082, 10'h083};
    do_write(25'h100, av, 16'h00A0, 1'b0, -1);
    // 2: read it back, contiguous valids.
    do_read(25'h100, av, 16'h00A0, 0);
    // 3: read with mem_ready low for 2 cycles after the first issue.
    do_read(25'h100, av, 16'h00A0, 2);

    // 4: rd+wr together -> write wins; wr dropped once mid-burst.
    av = '{10'h100, 10'h101, 10'h102, 10'h103};
    do_write(25'h200, av, 16'h00B0, 1'b1, 1);
    do_read(25'h200, av, 16'h00B0, 0);

    // 5: word address wrap at 2^10.
    av = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    do_write(25'h7FC, av, 16'h00C0, 1'b0, -1);
    do_read(25'h7FC, av, 16'h00C0, 0);

    // 6: reset during a read after two valids.
    step();
    io_in_rd   = 1'b1;
    io_in_addr = 25'h100;
    acc6       = cyc;
    push(exp_ra, 10'h080, 16'h0, 1'b0, acc6);
    push(exp_ra, 10'h081, 16'h0, 1'b0, acc6 + 1);
    push(exp_ra, 10'h082, 16'h0, 1'b0, acc6 + 2);
    push(exp_val, 10'h0, 16'h00A0, 1'b0, acc6 + 1);
    push(exp_val, 10'h0, 16'h00A1, 1'b0, acc6 + 2);
    step();
    io_in_rd = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(io_in_valid), 32'd0);
    chk("midrst_done", 32'(io_in_burstDone), 32'd0);
    chk("midrst_wait_n", 32'(io_in_wait_n), 32'd0);
    chk("midrst_dout", 32'(io_in_dout), 32'd0);
    chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
    step();
    step();
    reset = 1'b1;
    drain();
    av = '{10'h080, 10'h081, 10'h082, 10'h083};
    do_read(25'h100, av, 16'h00A0, 0);

    step();
    step();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
